// File: rtl/vls_if.sv
// vls_if: request, memory-port and writeback signals of the vector load/store sequencer
interface vls_if #(parameter int LANES = 8, parameter int AW = 8, parameter int DW = 32);
  logic                req_valid;
  logic                req_ready;
  logic                req_store;
  logic [AW-1:0]       req_base;
  logic [4:0]          req_vreg;
  logic [3:0]          req_vlen;
  logic [LANES*DW-1:0] req_sdata;
  logic                mem_req;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DW-1:0]       mem_rdata;
  logic                vwb_valid;
  logic [4:0]          vwb_addr;
  logic [LANES*DW-1:0] vwb_data;
  logic [LANES-1:0]    vwb_mask;
  logic                stall;
  logic                done;
  modport master (
    input  req_valid, req_store, req_base, req_vreg, req_vlen, req_sdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output vwb_valid, vwb_addr, vwb_data, vwb_mask, stall, done
  );
  modport slave (
    output req_valid, req_store, req_base, req_vreg, req_vlen, req_sdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  vwb_valid, vwb_addr, vwb_data, vwb_mask, stall, done
  );
endinterface

// File: rtl/vls_sequencer.sv
// vls_sequencer: issues one vector load/store as per-element SRAM accesses and writes gathered loads back
module vls_sequencer #(
  parameter int LANES = 8,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input logic   clk,
  input logic   rst_n,
  vls_if.master bus
);
  localparam int LW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DONE} state_t;
  state_t              st, nx;
  logic                store;
  logic [AW-1:0]       base;
  logic [4:0]          vreg;
  logic [3:0]          vlen, issue_cnt, rcv_cnt, cv;
  logic [LANES*DW-1:0] sdata, lbuf;
  logic [LANES-1:0]    mask;
  logic                acc, cap, issue, wb;
  assign cv    = bus.req_vlen > 4'(LANES) ? 4'(LANES) : bus.req_vlen;
  assign acc   = bus.req_valid && st == IDLE;
  assign issue = st == ISSUE;
  assign wb    = st == WB;
  assign cap   = bus.mem_rvalid && (issue || st == WAIT) && !store && rcv_cnt < vlen;
  assign mask  = LANES'(((LANES+1)'(1) << vlen) - (LANES+1)'(1));
  // state register, latched request, element counters and the load gather buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      store     <= 1'b0;
      base      <= '0;
      vreg      <= '0;
      vlen      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      sdata     <= '0;
      lbuf      <= '0;
    end else begin
      st <= nx;
      if (acc) begin
        store     <= bus.req_store;
        base      <= bus.req_base;
        vreg      <= bus.req_vreg;
        vlen      <= cv;
        sdata     <= bus.req_sdata;
        issue_cnt <= '0;
        rcv_cnt   <= '0;
        lbuf      <= '0;
      end else begin
        if (issue && bus.mem_gnt) issue_cnt <= issue_cnt + 4'd1;
        if (cap) begin
          lbuf[rcv_cnt[LW-1:0]*DW +: DW] <= bus.mem_rdata;
          rcv_cnt <= rcv_cnt + 4'd1;
        end
      end
    end
  end
  // next state: WB follows the cycle in which the final load element arrives
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = !bus.req_valid ? IDLE : (cv == 4'd0 ? DONE : ISSUE);
      ISSUE:   nx = (bus.mem_gnt && issue_cnt == vlen - 4'd1) ? (store ? DONE : WAIT) : ISSUE;
      WAIT:    nx = (rcv_cnt + 4'(cap) == vlen) ? WB : WAIT;
      default: nx = IDLE;
    endcase
  end
  assign bus.req_ready = st == IDLE;
  assign bus.stall     = st != IDLE;
  assign bus.mem_req   = issue;
  assign bus.mem_we    = issue && store;
  assign bus.mem_addr  = issue ? base + AW'(issue_cnt) : '0;
  assign bus.mem_wdata = issue ? sdata[issue_cnt[LW-1:0]*DW +: DW] : '0;
  assign bus.vwb_valid = wb;
  assign bus.vwb_addr  = wb ? vreg : '0;
  assign bus.vwb_data  = wb ? lbuf : '0;
  assign bus.vwb_mask  = wb ? mask : '0;
  assign bus.done      = wb || st == DONE;
endmodule

// File: tb/tb_vls_sequencer.sv
// tb_vls_sequencer: directed scoreboard bench for the vector load/store sequencer
module tb_vls_sequencer;
  localparam int LANES = 8, AW = 8, DW = 32, VW = LANES*DW;
  typedef struct {logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int cyc;} mem_t;
  typedef struct {logic [4:0] vreg; logic [LANES-1:0] mask; logic [VW-1:0] data; int cyc;} wb_t;
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vls_if #(.LANES(LANES), .AW(AW), .DW(DW)) bus();
  vls_sequencer #(.LANES(LANES), .AW(AW), .DW(DW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  mem_t exp_mem[$];
  wb_t  exp_wb[$];
  int   exp_done[$];
  rsp_t rsp[$];
  mem_t me;
  wb_t  we_;
  int   cyc = 0, lat = 1, n_chk = 0, n_err = 0, t = 0, dc = 0;
  bit   gnt_tog = 1'b0, spur = 1'b0;
  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s", name);
  endtask
  function automatic logic [VW-1:0] lanes(input logic [DW-1:0] first, input int n);
    logic [VW-1:0] v = '0;
    for (int i = 0; i < n; i++) v[i*DW +: DW] = first + DW'(i);
    return v;
  endfunction
  // memory model: grant pattern and in-order read returns, driven just after each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    bus.mem_gnt = gnt_tog ? cyc[0] : 1'b1;
    if (spur) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEADBEEF;
    end else if (rsp.size() > 0 && rsp[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rsp[0].data;
      void'(rsp.pop_front());
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  end
  // monitor: compares every presented access, writeback and done pulse against the queues
  always @(negedge clk) begin
    if (!bus.mem_req) chk("mem_idle_zero", VW'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), '0);
    else if (exp_mem.size() == 0) miss($sformatf("mem_unexpected: addr %h, no access expected", bus.mem_addr));
    else begin
      me = exp_mem[0];
      chk("mem_addr", VW'(bus.mem_addr), VW'(me.addr));
      chk("mem_we", VW'(bus.mem_we), VW'(me.we));
      chk("mem_wdata", VW'(bus.mem_wdata), VW'(me.wdata));
      if (bus.mem_gnt) begin
        if (me.cyc >= 0) chk("mem_cycle", VW'(cyc), VW'(me.cyc));
        void'(exp_mem.pop_front());
        if (!bus.mem_we) rsp.push_back('{cyc + lat, 32'hA0 + 32'(bus.mem_addr)});
      end
    end
    if (!bus.vwb_valid) begin
      chk("vwb_idle_data", bus.vwb_data, '0);
      chk("vwb_idle_ctl", VW'({bus.vwb_addr, bus.vwb_mask}), '0);
    end else if (exp_wb.size() == 0) miss("vwb_unexpected: writeback with none expected");
    else begin
      we_ = exp_wb.pop_front();
      chk("vwb_addr", VW'(bus.vwb_addr), VW'(we_.vreg));
      chk("vwb_mask", VW'(bus.vwb_mask), VW'(we_.mask));
      chk("vwb_data", bus.vwb_data, we_.data);
      chk("vwb_cycle", VW'(cyc), VW'(we_.cyc));
    end
    if (bus.done) begin
      if (exp_done.size() == 0) miss("done_unexpected: done pulse with none expected");
      else begin
        dc = exp_done.pop_front();
        if (dc >= 0) chk("done_cycle", VW'(cyc), VW'(dc));
      end
    end
  end
  task automatic send(input bit st, input logic [AW-1:0] base, input logic [4:0] vreg,
                      input logic [3:0] vlen, input logic [VW-1:0] sd, output int ta);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_base  = base;
    bus.req_vreg  = vreg;
    bus.req_vlen  = vlen;
    bus.req_sdata = sd;
    ta = -1;
    for (int k = 0; k < 50 && ta < 0; k++) begin
      @(negedge clk);
      if (bus.req_ready) ta = cyc;
    end
    if (ta < 0) miss("accept_timeout: req_ready stayed 0, need 1");
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
  endtask
  task automatic exp_acc(input logic [AW-1:0] base, input int n, input bit wr, input logic [VW-1:0] sd,
                         input bit timed, input int ta);
    for (int i = 0; i < n; i++)
      exp_mem.push_back('{AW'(base + AW'(i)), wr, sd[i*DW +: DW], timed ? ta + 1 + i : -1});
  endtask
  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      chk("stall_busy", VW'(bus.stall), VW'(1));
      seen = bus.done;
    end
    if (!seen) miss("done_timeout: no done pulse within 200 cycles");
    @(negedge clk);
    chk("ready_after_done", VW'({bus.req_ready, bus.stall}), VW'(2'b10));
  endtask
  task automatic check_reset();
    chk("reset_ctl", VW'({bus.req_ready, bus.stall, bus.done, bus.mem_req, bus.mem_we, bus.vwb_valid}), VW'(6'b100000));
    chk("reset_bus", VW'({bus.mem_addr, bus.mem_wdata, bus.vwb_addr, bus.vwb_mask}), '0);
    chk("reset_vwb_data", bus.vwb_data, '0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_base = '0; bus.req_vreg = '0;
    bus.req_vlen = '0; bus.req_sdata = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    // load vlen 8 at 0x10: lane i = 0xB0+i, writeback at T+10
    send(1'b0, 8'h10, 5'd3, 4'd8, '0, t);
    exp_acc(8'h10, 8, 1'b0, '0, 1'b1, t);
    exp_wb.push_back('{5'd3, 8'hFF, lanes(32'hB0, 8), t + 10});
    exp_done.push_back(t + 10);
    wait_done();
    // store vlen 5 at 0xFE with grant toggling, address wraps
    gnt_tog = 1'b1;
    send(1'b1, 8'hFE, 5'd0, 4'd5, lanes(32'hCAFE0000, 5), t);
    exp_mem.push_back('{8'hFE, 1'b1, 32'hCAFE0000, -1});
    exp_mem.push_back('{8'hFF, 1'b1, 32'hCAFE0001, -1});
    exp_mem.push_back('{8'h00, 1'b1, 32'hCAFE0002, -1});
    exp_mem.push_back('{8'h01, 1'b1, 32'hCAFE0003, -1});
    exp_mem.push_back('{8'h02, 1'b1, 32'hCAFE0004, -1});
    exp_done.push_back(-1);
    wait_done();
    gnt_tog = 1'b0;
    // load vlen 3 with read latency 4: writeback at T+8, upper lanes zero
    lat = 4;
    send(1'b0, 8'h40, 5'd7, 4'd3, '0, t);
    exp_acc(8'h40, 3, 1'b0, '0, 1'b1, t);
    exp_wb.push_back('{5'd7, 8'h07, {160'h0, 32'hE2, 32'hE1, 32'hE0}, t + 8});
    exp_done.push_back(t + 8);
    wait_done();
    // vlen 0: done at T+1, no access
    lat = 1;
    send(1'b0, 8'h00, 5'd2, 4'd0, '0, t);
    exp_done.push_back(t + 1);
    wait_done();
    // vlen 12 clamps to 8
    send(1'b0, 8'h20, 5'd9, 4'd12, '0, t);
    exp_acc(8'h20, 8, 1'b0, '0, 1'b1, t);
    exp_wb.push_back('{5'd9, 8'hFF, lanes(32'hC0, 8), t + 10});
    exp_done.push_back(t + 10);
    wait_done();
    // reset after two grants of a load, its read data arriving afterwards
    lat = 3;
    send(1'b0, 8'h50, 5'd4, 4'd8, '0, t);
    exp_acc(8'h50, 2, 1'b0, '0, 1'b1, t);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_reset();
    repeat (3) @(posedge clk);
    lat = 1;
    send(1'b0, 8'h60, 5'd1, 4'd2, '0, t);
    exp_acc(8'h60, 2, 1'b0, '0, 1'b1, t);
    exp_wb.push_back('{5'd1, 8'h03, {192'h0, 32'h101, 32'h100}, t + 4});
    exp_done.push_back(t + 4);
    wait_done();
    // spurious read data while idle and during a store
    spur = 1'b1;
    repeat (2) @(posedge clk);
    send(1'b1, 8'h80, 5'd0, 4'd3, lanes(32'h77000010, 3), t);
    exp_acc(8'h80, 3, 1'b1, lanes(32'h77000010, 3), 1'b1, t);
    exp_done.push_back(t + 4);
    wait_done();
    spur = 1'b0;
    repeat (2) @(posedge clk);
    lat = 2;
    send(1'b0, 8'h90, 5'd30, 4'd4, '0, t);
    exp_acc(8'h90, 4, 1'b0, '0, 1'b1, t);
    exp_wb.push_back('{5'd30, 8'h0F, {128'h0, 32'h133, 32'h132, 32'h131, 32'h130}, t + 7});
    exp_done.push_back(t + 7);
    wait_done();
    repeat (5) @(negedge clk);
    chk("exp_mem_left", VW'(exp_mem.size()), '0);
    chk("exp_wb_left", VW'(exp_wb.size()), '0);
    chk("exp_done_left", VW'(exp_done.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vls_sequencer.md
# vls_sequencer

Vector load/store sequencer between ID/EX and the shared data SRAM port. It accepts one vector LW_V/SW_V request, then issues per-element scalar memory accesses through a request/grant port. Load results are gathered into an 8-lane buffer and written back to the vector register file in one cycle. The pipeline is stalled for the whole operation, which removes the per-element counter from the decode stage.

## Interface
- LANES, 8, number of vector lanes (max vlen)
- AW, 8, data SRAM word-address width
- DW, 32, element width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  vector memory op request
- req_ready  out  1  sequencer can accept (IDLE)
- req_store  in  1  1 = SW_V, 0 = LW_V
- req_base  in  AW  element-0 word address
- req_vreg  in  5  vector register index (load destination)
- req_vlen  in  4  element count; values > LANES are clamped to LANES
- req_sdata  in  LANES*DW  store data, lane i at bits [i*DW +: DW]
- mem_req  out  1  element access request
- mem_we  out  1  write enable for the current access
- mem_addr  out  AW  element address
- mem_wdata  out  DW  store element
- mem_gnt  in  1  access accepted this cycle
- mem_rvalid  in  1  read data valid, returned in order, latency ≥1 after grant
- mem_rdata  in  DW  read data
- vwb_valid  out  1  vector register write strobe
- vwb_addr  out  5  vector register index
- vwb_data  out  LANES*DW  gathered load data
- vwb_mask  out  LANES  lane i = (i < vlen)
- stall  out  1  freeze the IF/ID pipeline
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, WB, DONE.
- Accept: req_valid & req_ready at a clock edge. On accept, the block latches the request fields and clears issue_cnt, rcv_cnt and the load buffer.
- IDLE -> DONE if clamped vlen = 0, with no memory access. Otherwise IDLE -> ISSUE.
- ISSUE:
  - Drive mem_req=1, mem_addr = base + issue_cnt (mod 2^AW, wraps), mem_we = store, mem_wdata = lane issue_cnt.
  - Hold all mem_* stable until mem_gnt. Each grant increments issue_cnt.
  - On the grant of element vlen-1: store -> DONE; load -> WAIT.
- Load data capture:
  - In ISSUE or WAIT, each mem_rvalid writes mem_rdata into lane rcv_cnt, then rcv_cnt increments.
  - mem_rvalid in IDLE/WB/DONE, or during a store, is ignored.
- WAIT -> WB in the cycle after the rvalid that makes rcv_cnt = vlen.
- WB:
  - vwb_valid=1, vwb_addr = vreg, vwb_data = buffer, vwb_mask = lanes below vlen.
  - Lanes ≥ vlen read 0.
  - done=1. Next state IDLE.
- DONE: done=1, next state IDLE.
- stall = (state != IDLE). req_ready = (state == IDLE).
- Reset, including mid-operation: state IDLE, counters and buffer cleared. Outstanding rvalids after reset are ignored.

## Timing
- Reset values:
  - req_ready=1 (the only output at 1).
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - vwb_valid=0, vwb_addr=0, vwb_data=0, vwb_mask=0.
  - stall=0, done=0.
- mem_* and vwb_* outputs are zero whenever they are not asserted.
- Accept at edge of cycle T: stall and mem_req go high in T+1.
- Store, vlen=N, grant every cycle: issue T+1..T+N, done at T+N+1, req_ready at T+N+2.
- Load, vlen=N, grant every cycle, rvalid 1 cycle after grant: issue T+1..T+N, data T+2..T+N+1, vwb_valid and done at T+N+2, IDLE at T+N+3.
- Each grant withheld adds one cycle. Extra read latency extends WAIT only.
- No new request is accepted in the done/WB cycle. The earliest back-to-back accept is in the IDLE cycle that follows.

## Test plan
- Load, vlen=8, base=0x10, gnt=1, rvalid latency 1, rdata=0xA0+addr:
  - addresses 0x10..0x17 on T+1..T+8
  - vwb_valid at T+10 with vreg=3, mask=0xFF, lane i = 0xB0+i
- Store, vlen=5, base=0xFE, gnt toggling 1/0:
  - addresses 0xFE, 0xFF, 0x00, 0x01, 0x02 (wrap), each held until granted
  - wdata equals lanes 0..4
  - exactly one done pulse, no vwb_valid
- Load, vlen=3, rvalid latency 4:
  - WAIT held until the third rvalid
  - vwb_mask=0x07, lanes 3..7 = 0
  - stall high throughout
- vlen=0 and vlen=12:
  - 0 gives done at T+1 with no mem_req
  - 12 is clamped to 8: 8 accesses, mask=0xFF
- rst_n low mid-load (after 2 grants), with rvalids arriving afterwards:
  - all outputs at reset values, req_ready=1
  - a following load returns only new data
- Spurious mem_rvalid in IDLE and during a store:
  - buffer unchanged; the next load writes back only the correct data
